// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin grant sequencer: FSM state encoding
// and default sizing.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_N       = 3;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/decoder_nbit.sv
// Binary-to-one-hot decoder with enable; all-zero output when disabled.
module decoder_nbit #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]    a,
  input  logic            enable,
  output logic [2**N-1:0] y
);

  always_comb begin
    y = '0;
    if (enable) y[a] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter holding each grant until release (done or owner drops req).
// Define ARB_TIMEOUT_EN to add a hold limit of TIMEOUT cycles and the timeout pulse port.
module rr_grant_sequencer
  import rr_arb_pkg::*;
#(
  parameter int unsigned N = DEF_N
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2**N-1:0] req,
  input  logic            done,
  output logic [2**N-1:0] gnt,
  output logic [N-1:0]    gnt_idx,
  output logic            gnt_valid
`ifdef ARB_TIMEOUT_EN
  , output logic          timeout
`endif
);

  localparam int unsigned NREQ = 2**N;

  arb_state_t state;
  logic [N-1:0] ptr;
  logic [N-1:0] sel_idx;
  logic [N-1:0] cand;
  logic         sel_found;
  logic         release_req;

  // First set request at or after ptr, wrapping through the top index.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = ptr + N'(i);
      if (!sel_found && req[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign release_req = done || !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [15:0] hold_cnt;
  logic        hold_expired;
  assign hold_expired = (hold_cnt == 16'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          gnt_valid <= 1'b0;
          if (sel_found) begin
            gnt_idx   <= sel_idx;
            gnt_valid <= 1'b1;
            state     <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (release_req) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 1'b1;
            state     <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          // A normal release on the expiry cycle takes precedence and suppresses the pulse.
          else if (hold_expired) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 1'b1;
            state     <= ST_IDLE;
            timeout   <= 1'b1;
          end else begin
            hold_cnt  <= hold_cnt + 16'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  decoder_nbit #(.N(N)) u_gnt_dec (
    .a      (gnt_idx),
    .enable (gnt_valid),
    .y      (gnt)
  );

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer (N=3); timeout scenario built when ARB_TIMEOUT_EN is defined.
module tb_rr_grant_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
  rr_grant_sequencer #(.N(3), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );
`else
  rr_grant_sequencer #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    logic [7:0] onehot;
    onehot = 8'b1 << idx;
    check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    check({tag, "_idx"},   32'(gnt_idx),   32'(idx));
    check({tag, "_gnt"},   32'(gnt),       32'(onehot));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
    check({tag, "_gnt"},   32'(gnt),       32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Structural invariants, sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0] exp_gnt;
    exp_gnt = gnt_valid ? (8'b1 << gnt_idx) : 8'h00;
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    check("gnt_form", 32'(gnt), 32'(exp_gnt));
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    tick();
    tick();
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check_idle("rst");
`ifdef ARB_TIMEOUT_EN
    check("rst_timeout", 32'(timeout), 32'd0);
`endif
    rst_n = 1'b1;

    // Single requester, one-edge latency.
    req = 8'b0000_0100;
    tick();
    check_grant("t1", 3'd2);
    done = 1'b1;
    tick();
    check_idle("t1_rel");
    done = 1'b0;
    req  = '0;
    tick();
    check_idle("t1_quiet");

    // Full rotation 0..7,0 with one idle cycle between grants.
    do_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      check_grant("t2", 3'(k % 8));
      done = 1'b1;
      tick();
      check_idle("t2_gap");
      done = 1'b0;
      tick();
    end
    // Ninth grant (idx 0) was released by the loop tail? No: the loop re-grants after the last gap.
    check_grant("t2_next", 3'd1);
    done = 1'b1;
    req  = 8'b0010_0000;
    tick();
    check_idle("t2_end");
    done = 1'b0;

    // Wrap: owner 5 releases with req {5,0} pending -> ptr=6 -> grant 0.
    tick();
    check_grant("t3_own5", 3'd5);
    done = 1'b1;
    req  = 8'b0010_0001;
    tick();
    check_idle("t3_rel");
    done = 1'b0;
    tick();
    check_grant("t3_wrap", 3'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();
    check_idle("t3_quiet");

    // Owner 3 drops its request; non-owner requests ignored during a grant.
    req = 8'b0001_1000;
    tick();
    check_grant("t4_own3", 3'd3);
    req = 8'b0001_0000;
    tick();
    check_idle("t4_drop");
    tick();
    check_grant("t4_own4", 3'd4);
    req = 8'hFF;
    tick();
    check_grant("t4_hold", 3'd4);
    done = 1'b1;
    tick();
    check_idle("t4_rel");
    done = 1'b0;

    // Async reset mid-grant of owner 5.
    req = 8'b0010_0000;
    tick();
    check_grant("t5_own5", 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t5_async");
    req = 8'hFF;
    tick();
    rst_n = 1'b1;
    tick();
    check_grant("t5_after", 3'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // Forced release after exactly TIMEOUT=4 held cycles, then done-vs-timeout tie.
    do_reset();
    req = 8'b0000_0110;
    tick();
    check_grant("t6_c0", 3'd1);
    check("t6_to0", 32'(timeout), 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check_grant("t6_hold", 3'd1);
      check("t6_to_hold", 32'(timeout), 32'd0);
    end
    tick();
    check_idle("t6_forced");
    check("t6_pulse", 32'(timeout), 32'd1);
    tick();
    check_grant("t6_next", 3'd2);
    check("t6_pulse_end", 32'(timeout), 32'd0);
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    check_idle("t6_tie");
    check("t6_tie_to", 32'(timeout), 32'd0);
    done = 1'b0;
    req  = '0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
